// File: rtl/apb_mem_slave_if.sv
// rtl/apb_mem_slave_if.sv - APB bus bundle between the summing requester and the memory completer
interface apb_mem_slave_if;
    logic        psel_i;
    logic        penable_i;
    logic [7:0]  paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic [15:0] acc_count_o;

    modport slave (
        input  psel_i,
        input  penable_i,
        input  paddr_i,
        input  pwrite_i,
        input  pwdata_i,
        output prdata_o,
        output pready_o,
        output pslverr_o,
        output acc_count_o
    );

    modport master (
        output psel_i,
        output penable_i,
        output paddr_i,
        output pwrite_i,
        output pwdata_i,
        input  prdata_o,
        input  pready_o,
        input  pslverr_o,
        input  acc_count_o
    );
endinterface

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB word-memory completer with reset image, wait states and range errors
module apb_mem_slave #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] INIT_BASE   = 32'h0000_0001,
    parameter logic [31:0] INIT_STEP   = 32'h0000_0001
) (
    input  logic          pclk_i,
    input  logic          preset_i,
    apb_mem_slave_if.slave bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);
    localparam logic [3:0] WAIT_W  = 4'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wcnt;
    logic [7:0]  r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];
    logic [15:0] r_acc_count;

    logic          w_active;
    logic          w_done;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // The access phase is live only while the requester keeps psel/penable high.
    assign w_active = (r_state == S_ACCESS) && bus.psel_i && bus.penable_i;
    assign w_done   = w_active && (r_wcnt == WAIT_W);
    assign w_err    = {1'b0, r_addr} >= DEPTH_W;
    assign w_idx    = r_addr[AW-1:0];

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 4'd0;
            r_addr      <= 8'd0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
            r_acc_count <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_BASE + INIT_STEP * 32'(i);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.psel_i && !bus.penable_i) begin
                        r_addr  <= bus.paddr_i;
                        r_write <= bus.pwrite_i;
                        r_wdata <= bus.pwdata_i;
                        r_wcnt  <= 4'd0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!w_active) begin
                        r_state <= S_IDLE;
                    end else if (w_done) begin
                        if (r_write && !w_err) begin
                            r_mem[w_idx] <= r_wdata;
                        end
                        r_acc_count <= r_acc_count + 16'd1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pready_o    = w_done;
    assign bus.pslverr_o   = w_done && w_err;
    assign bus.prdata_o    = (w_done && !r_write && !w_err) ? r_mem[w_idx] : 32'd0;
    assign bus.acc_count_o = r_acc_count;
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - directed and randomized checks of apb_mem_slave against a word-array model
module tb_apb_mem_slave;
    logic        clk;
    logic        rst;
    logic        sel0;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        m_pslverr;
    logic [15:0] m_acc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_setup;

    logic [31:0] mdl_mem [2][16];
    int          mdl_acc [2];

    apb_mem_slave_if bus0 ();
    apb_mem_slave_if bus1 ();

    assign bus1.psel_i    = psel & ~sel0;
    assign bus0.psel_i    = psel & sel0;
    assign bus1.penable_i = penable;
    assign bus0.penable_i = penable;
    assign bus1.paddr_i   = paddr;
    assign bus0.paddr_i   = paddr;
    assign bus1.pwrite_i  = pwrite;
    assign bus0.pwrite_i  = pwrite;
    assign bus1.pwdata_i  = pwdata;
    assign bus0.pwdata_i  = pwdata;

    assign m_prdata  = sel0 ? bus0.prdata_o    : bus1.prdata_o;
    assign m_pready  = sel0 ? bus0.pready_o    : bus1.pready_o;
    assign m_pslverr = sel0 ? bus0.pslverr_o   : bus1.pslverr_o;
    assign m_acc     = sel0 ? bus0.acc_count_o : bus1.acc_count_o;

    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(1)) u_dut_w1 (
        .pclk_i   (clk),
        .preset_i (rst),
        .bus      (bus1.slave)
    );

    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .pclk_i   (clk),
        .preset_i (rst),
        .bus      (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_acc[d] = 0;
            for (int i = 0; i < 16; i++) mdl_mem[d][i] = 32'(i + 1);
        end
    endtask

    task automatic scramble();
        paddr  = 8'($urandom);
        pwdata = $urandom;
        pwrite = 1'($urandom);
    endtask

    task automatic go_idle();
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        #1;
    endtask

    task automatic check_acc(input int d, input string tag);
        sel0 = (d == 0);
        #1;
        check(tag, 32'(m_acc), 32'(mdl_acc[d] & 16'hFFFF));
    endtask

    task automatic xfer(input int d, input logic [7:0] addr, input logic wr,
                        input logic [31:0] data, input string tag, output logic [31:0] rd);
        int          n;
        logic        e_err;
        logic [31:0] e_rd;
        @(negedge clk);
        last_setup = cyc;
        sel0    = (d == 0);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        #1;
        check({tag, ".setup_rdy"}, 32'(m_pready), 32'd0);
        @(negedge clk);
        penable = 1'b1;
        scramble();
        #1;
        n = 1;
        while (!m_pready && n < 20) begin
            @(negedge clk);
            scramble();
            #1;
            n++;
        end
        check({tag, ".lat"}, 32'(n), (d == 0) ? 32'd1 : 32'd2);
        e_err = (addr >= 8'd16);
        if (wr && !e_err) mdl_mem[d][addr[3:0]] = data;
        e_rd = (!wr && !e_err) ? mdl_mem[d][addr[3:0]] : 32'd0;
        check({tag, ".rdata"}, m_prdata, e_rd);
        check({tag, ".err"}, 32'(m_pslverr), 32'(e_err));
        check({tag, ".acc"}, 32'(m_acc), 32'(mdl_acc[d] & 16'hFFFF));
        mdl_acc[d]++;
        rd = m_prdata;
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        int          t0;
        int          d;
        logic [7:0]  a;
        rst = 1'b1; sel0 = 1'b0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'd0; pwdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst.rdy1", 32'(bus1.pready_o), 32'd0);
        check("rst.err1", 32'(bus1.pslverr_o), 32'd0);
        check("rst.rd1", bus1.prdata_o, 32'd0);
        check("rst.acc1", 32'(bus1.acc_count_o), 32'd0);
        check("rst.rdy0", 32'(bus0.pready_o), 32'd0);
        check("rst.acc0", 32'(bus0.acc_count_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Enable without a preceding setup phase must be ignored.
        psel = 1'b1; penable = 1'b1; paddr = 8'd0; pwrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("nosetup.rdy", 32'(m_pready), 32'd0);
        end
        go_idle();
        check_acc(1, "nosetup.acc");

        xfer(1, 8'd0, 1'b0, 32'd0, "t1.a0", r0);
        xfer(1, 8'd1, 1'b0, 32'd0, "t1.a1", r1);
        go_idle();
        check("t1.d0", r0, 32'd1);
        check("t1.d1", r1, 32'd2);
        check("t1.sum", r0 + r1, 32'd3);
        check_acc(1, "t1.acc");
        check("t1.acc2", 32'(m_acc), 32'd2);

        xfer(1, 8'd5, 1'b1, 32'hDEAD_BEEF, "t2.w5", r0);
        xfer(1, 8'd5, 1'b0, 32'd0, "t2.r5", r0);
        xfer(1, 8'd6, 1'b0, 32'd0, "t2.r6", r1);
        go_idle();
        check("t2.d5", r0, 32'hDEAD_BEEF);
        check("t2.d6", r1, 32'd7);

        xfer(1, 8'd16, 1'b0, 32'd0, "t3.r16", r0);
        xfer(1, 8'd200, 1'b1, 32'h1234_5678, "t3.w200", r1);
        go_idle();
        check("t3.acc", 32'(m_acc), 32'd7);
        xfer(1, 8'd15, 1'b0, 32'd0, "t3.r15", r0);
        go_idle();
        check("t3.d15", r0, 32'd16);

        xfer(0, 8'd0, 1'b0, 32'd0, "t4.b2b", r0);
        t0 = last_setup;
        for (int i = 1; i < 10; i++) xfer(0, 8'(i), 1'b0, 32'd0, "t4.b2b", r0);
        @(negedge clk); #1;
        check("t4.cycles", 32'(cyc - t0), 32'd20);
        check("t4.last", r0, 32'd10);
        psel = 1'b0; penable = 1'b0;
        check_acc(0, "t4.acc");

        // Abort a write during its wait state.
        @(negedge clk);
        sel0 = 1'b0; psel = 1'b1; penable = 1'b0;
        paddr = 8'd3; pwrite = 1'b1; pwdata = 32'hCAFE_0003;
        @(negedge clk); penable = 1'b1; #1;
        check("t5.wait_rdy", 32'(m_pready), 32'd0);
        @(negedge clk); penable = 1'b0; #1;
        check("t5.abort_rdy", 32'(m_pready), 32'd0);
        go_idle();
        xfer(1, 8'd3, 1'b0, 32'd0, "t5.r3", r0);
        go_idle();
        check("t5.d3", r0, 32'd4);
        check_acc(1, "t5.acc");
        check("t5.acc9", 32'(m_acc), 32'd9);

        // Reset lands on the completing edge of a write.
        @(negedge clk);
        sel0 = 1'b0; psel = 1'b1; penable = 1'b0;
        paddr = 8'd2; pwrite = 1'b1; pwdata = 32'hBAD0_0002;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; psel = 1'b0; penable = 1'b0; #1;
        check("t6.rdy", 32'(m_pready), 32'd0);
        model_reset();
        xfer(1, 8'd2, 1'b0, 32'd0, "t6.r2", r0);
        go_idle();
        check("t6.d2", r0, 32'd3);
        check("t6.acc", 32'(m_acc), 32'd1);
        check_acc(0, "t6.acc0");

        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
            xfer(d, a, 1'($urandom), $urandom, "rnd", r0);
        end
        go_idle();
        check_acc(0, "rnd.acc0");
        check_acc(1, "rnd.acc1");
        for (int i = 0; i < 16; i++) begin
            xfer(1, 8'(i), 1'b0, 32'd0, "dump1", r0);
            xfer(0, 8'(i), 1'b0, 32'd0, "dump0", r0);
        end
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB completer that answers the pair-summing APB requester on the same bus.
- Holds a small word memory with a deterministic reset image, so the requester's summed results are predictable.
- Supports reads and writes with a configurable number of wait states.
- Flags out-of-range addresses with pslverr_o.

Parameters:
- DEPTH, 16, number of 32-bit words; valid addresses 0..DEPTH-1 (DEPTH ≤ 256).
- WAIT_CYCLES, 1, access-phase cycles with pready_o low before completion (0..15).
- INIT_BASE, 32'h0000_0001, reset value of word 0.
- INIT_STEP, 32'h0000_0001, increment between consecutive words at reset.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- preset_i  in  1  reset; one clock; reset is synchronous and active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- paddr_i  in  8  word address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data; valid only when pready_o=1 and the access is a read, otherwise 0.
- pready_o  out  1  transfer completes this cycle.
- pslverr_o  out  1  error, qualified by pready_o.
- acc_count_o  out  16  number of completed accesses, including errored ones; wraps at 2^16.

Behaviour:
- Reset (preset_i=1 at an edge):
  - FSM goes to IDLE; wait counter and acc_count_o clear to 0.
  - mem[i] = INIT_BASE + i*INIT_STEP, with 32-bit wrap.
  - Outputs prdata_o=0, pready_o=0, pslverr_o=0.
  - Reset overrides any access in progress; no write commits in that cycle.
- FSM states:
  - IDLE: if psel_i=1 and penable_i=0 (setup phase), capture paddr_i, pwrite_i and pwdata_i into request registers, clear wcnt, go to ACCESS.
  - IDLE ignores psel_i=1 with penable_i=1 (no setup seen): stays IDLE, pready_o=0.
  - ACCESS, penable_i=1 and wcnt<WAIT_CYCLES: wcnt++, pready_o=0.
  - ACCESS, penable_i=1 and wcnt==WAIT_CYCLES: pready_o=1 combinationally from state/wcnt; the transfer completes at this edge; next state is IDLE.
  - ACCESS, psel_i=0 or penable_i=0 (protocol abort): return to IDLE; no write, no count increment.
- Latency: with WAIT_CYCLES=W, pready_o rises in access cycle W+1, counting from 1. W=0 gives a zero-wait transfer (setup, access) in 2 cycles total.
- Error:
  - addr_q ≥ DEPTH gives pslverr_o=1 in the pready_o cycle.
  - An errored read returns prdata_o=0; an errored write is discarded.
  - Errored accesses take the same wait states as good ones.
- Read: prdata_o = mem[addr_q] during the pready_o cycle, driven combinationally from the array.
- Write: mem[addr_q] <= data_q at the completing edge. A read of the same address in the next transfer returns the new value.
- Back-to-back: a new setup phase may appear in the cycle right after completion. IDLE accepts it, so there is no dead cycle beyond the APB setup phase.
- Request registers hold the values captured in setup. Changes to paddr_i, pwrite_i or pwdata_i during the access phase are ignored.
- acc_count_o increments by 1 on each completing edge, including errors, and wraps FFFF→0000.

Test Plan:
- Reset, then with W=1 read addr 0, then addr 1 → prdata_o = 1 then 2; each pready_o appears in the 2nd access cycle; acc_count_o=2; a requester summing the pair gets 3.
- Write 32'hDEAD_BEEF to addr 5, then read addr 5 → 32'hDEAD_BEEF, pslverr_o=0. A read of addr 6 still returns 7.
- Read addr 16 and write addr 200 → pslverr_o=1 with pready_o on each. The read returns 0. mem is unchanged (a read of addr 15 returns 16). acc_count_o advances by 2.
- W=0, ten back-to-back reads of addrs 0..9 → pready_o in every access cycle, data 1..10, 20 cycles total.
- Drop penable_i during the wait state of a write to addr 3, then read addr 3 → 4 (write not committed); acc_count_o counts only the read.
- Assert preset_i mid-access after writing addr 2 → pready_o=0 next cycle; a later read of addr 2 returns 3 and acc_count_o=1.
